// File: rtl/dsa_pkg.sv
// Shared types and helpers for the digit-serial adder/subtractor.
package dsa_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Digit counter needs at least one bit even when a single digit covers the word.
    function automatic int cnt_width(input int ndig);
        return (ndig <= 1) ? 1 : $clog2(ndig);
    endfunction

endpackage

// File: rtl/digit_adder.sv
// Combinational DIGIT-bit ripple of full-adder cells; also exposes the carry into the top cell.
module digit_adder #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             cin,
    output logic [DIGIT-1:0] s,
    output logic             cout,
    output logic             c_msb_in
);

    logic [DIGIT:0] c;

    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = cin;
        for (int i = 0; i < DIGIT; i++) begin
            s[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    end

    assign cout     = c[DIGIT];
    assign c_msb_in = c[DIGIT-1];

endmodule

// File: rtl/digit_serial_adder.sv
// Digit-serial ripple adder/subtractor with valid/ready handshakes on both sides.
// Optional signed-overflow output enabled by defining DSA_OVERFLOW_EN.
module digit_serial_adder
    import dsa_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             op_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef DSA_OVERFLOW_EN
    ,
    output logic             ovf
`endif
);

    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = cnt_width(NDIG);

    if (DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_cfg
        $fatal(1, "digit_serial_adder: WIDTH must be a positive multiple of DIGIT");
    end

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, s_q, s_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;

    logic [DIGIT-1:0] dig_s;
    logic             dig_cout, dig_cmsb;
    logic [WIDTH-1:0] dig_ext, s_shift;

    digit_adder #(.DIGIT(DIGIT)) u_digit (
        .a        (a_q[DIGIT-1:0]),
        .b        (b_q[DIGIT-1:0]),
        .cin      (carry_q),
        .s        (dig_s),
        .cout     (dig_cout),
        .c_msb_in (dig_cmsb)
    );

    // New digit enters at the top so the word is in place after NDIG shifts.
    assign dig_ext = WIDTH'(dig_s);
    assign s_shift = (s_q >> DIGIT) | (dig_ext << (WIDTH - DIGIT));

`ifdef DSA_OVERFLOW_EN
    logic ovf_q, ovf_d;
    assign ovf = ovf_q;
`else
    logic unused_cmsb;
    assign unused_cmsb = dig_cmsb;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        s_d     = s_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
`ifdef DSA_OVERFLOW_EN
        ovf_d   = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b ^ {WIDTH{op_sub}};
                    carry_d = op_sub | cin;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_d     = a_q >> DIGIT;
                b_d     = b_q >> DIGIT;
                s_d     = s_shift;
                carry_d = dig_cout;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CW'(NDIG - 1)) begin
                    sum_d   = s_shift;
                    cout_d  = dig_cout;
`ifdef DSA_OVERFLOW_EN
                    ovf_d   = dig_cmsb ^ dig_cout;
`endif
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
`ifdef DSA_OVERFLOW_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
`ifdef DSA_OVERFLOW_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    // Operand and partial-sum shifters carry no control meaning, so they skip reset.
    always_ff @(posedge clk) begin
        a_q <= a_d;
        b_q <= b_d;
        s_q <= s_d;
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign sum       = sum_q;
    assign cout      = cout_q;

endmodule

// File: tb/tb_digit_serial_adder.sv
// Self-checking bench for digit_serial_adder (WIDTH=8, DIGIT=2); covers ovf when DSA_OVERFLOW_EN is defined.
module tb_digit_serial_adder;

    localparam int W  = 8;
    localparam int D  = 2;
    localparam int ND = W / D;

    logic         clk = 1'b0;
    logic         reset, in_valid, in_ready, cin, op_sub, out_valid, out_ready, cout;
    logic [W-1:0] a, b, sum;
`ifdef DSA_OVERFLOW_EN
    logic         ovf;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    digit_serial_adder #(.WIDTH(W), .DIGIT(D)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .op_sub    (op_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
`ifdef DSA_OVERFLOW_EN
        ,
        .ovf       (ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the operands.
    function automatic logic [W:0] ref_result(input logic [W-1:0] ra, rb, input logic rc, rs);
        int unsigned r;
        if (rs) begin
            r = (int'(ra) - int'(rb)) & ((1 << W) - 1);
            return {(ra >= rb), r[W-1:0]};
        end
        r = int'(ra) + int'(rb) + int'(rc);
        return r[W:0];
    endfunction

    function automatic logic ref_ovf(input logic [W-1:0] ra, rb, input logic rc, rs);
        int r;
        r = rs ? (int'($signed(ra)) - int'($signed(rb)))
               : (int'($signed(ra)) + int'($signed(rb)) + int'(rc));
        return (r > 127) || (r < -128);
    endfunction

    task automatic start_op(input logic [W-1:0] ta, tb_, input logic tc, ts);
        @(negedge clk);
        check("in_ready_before_op", in_ready, 1);
        a = ta; b = tb_; cin = tc; op_sub = ts; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_result(input string tag, input logic [W-1:0] ta, tb_, input logic tc, ts);
        int cyc;
        logic [W:0] exp;
        cyc = 0;
        while (!out_valid && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        exp = ref_result(ta, tb_, tc, ts);
        check({tag, "_latency"}, cyc, ND);
        check({tag, "_sum"}, sum, exp[W-1:0]);
        check({tag, "_cout"}, cout, exp[W]);
`ifdef DSA_OVERFLOW_EN
        check({tag, "_ovf"}, ovf, ref_ovf(ta, tb_, tc, ts));
`endif
    endtask

    task automatic full_op(input string tag, input logic [W-1:0] ta, tb_, input logic tc, ts);
        start_op(ta, tb_, tc, ts);
        wait_result(tag, ta, tb_, tc, ts);
        @(negedge clk);
        check({tag, "_in_ready_after"}, in_ready, 1);
        check({tag, "_out_valid_after"}, out_valid, 0);
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        logic [W:0]   hold;
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; cin = 1'b0; op_sub = 1'b0;
        #12;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_sum", sum, 0);
        check("rst_cout", cout, 0);
`ifdef DSA_OVERFLOW_EN
        check("rst_ovf", ovf, 0);
`endif
        @(negedge clk);
        reset = 1'b0;

        full_op("add", 8'h3C, 8'h05, 1'b0, 1'b0);
        check("add_sum_const", sum, 8'h41);
        full_op("wrap", 8'hFF, 8'h01, 1'b1, 1'b0);
        check("wrap_sum_const", sum, 8'h01);
        check("wrap_cout_const", cout, 1);
        full_op("sub_neg", 8'h10, 8'h20, 1'b0, 1'b1);
        check("sub_neg_const", sum, 8'hF0);
        full_op("sub_pos", 8'h20, 8'h10, 1'b1, 1'b1);
        check("sub_pos_const", {cout, sum}, 9'h110);
`ifdef DSA_OVERFLOW_EN
        full_op("ovf_pos", 8'h7F, 8'h01, 1'b0, 1'b0);
        check("ovf_pos_const", {ovf, sum}, 9'h180);
        full_op("ovf_none", 8'hFF, 8'h01, 1'b0, 1'b0);
        check("ovf_none_const", ovf, 0);
`endif

        // Backpressure: result must hold and new operands must be ignored.
        out_ready = 1'b0;
        start_op(8'h55, 8'h22, 1'b0, 1'b0);
        wait_result("bp", 8'h55, 8'h22, 1'b0, 1'b0);
        hold = {cout, sum};
        for (int i = 0; i < 5; i++) begin
            a = W'($urandom); b = W'($urandom); op_sub = 1'b0; in_valid = 1'b1;
            @(negedge clk);
            check("bp_out_valid", out_valid, 1);
            check("bp_in_ready", in_ready, 0);
            check("bp_result_hold", {cout, sum}, hold);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_in_ready", in_ready, 1);
        check("bp_release_out_valid", out_valid, 0);
        check("bp_post_hold", {cout, sum}, 9'h077);

        // Reset after two digits of a run aborts it.
        start_op(8'hF0, 8'h0F, 1'b1, 1'b0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("rst_mid_out_valid", out_valid, 0);
        check("rst_mid_sum", sum, 0);
        check("rst_mid_cout", cout, 0);
        check("rst_mid_in_ready", in_ready, 1);
        @(negedge clk);
        reset = 1'b0;
        repeat (ND + 2) @(negedge clk);
        check("rst_mid_no_result", out_valid, 0);
        full_op("post_rst", 8'h3C, 8'h05, 1'b0, 1'b0);
        check("post_rst_const", sum, 8'h41);

        for (int i = 0; i < 24; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            full_op("rand", ra, rb, 1'($urandom), 1'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
